pipelined_integer_lane: RTL
===========================

Name: pipelined_integer_lane

Overview:
Parametrised integer execution lane for the out-of-order core. It accepts one issued integer operation per cycle from the reservation station and evaluates it with the existing ALU module. The result and ROB index travel through PIPE_DEPTH elastic valid/ready stages to the ROB write-back port. It supports full back-pressure, whole-lane flush, link-address generation and an occupancy count.

Parameters:
XLEN, 64, operand/result width
ROB_INDEX_WIDTH, 8, ROB index bits
DECODED_INSTR_WIDTH, 6, decoded op width; ALU uses bits [5:0]
PIPE_DEPTH, 2, number of result register stages (>=1)
LINK_OP, 6'd1, decoded op code meaning "write PC+INSTR_BYTES"
INSTR_BYTES, 4, link increment
CNT_WIDTH, $clog2(PIPE_DEPTH+2), width of inflight_count

Ports:
clock  input  1  clock
reset  input  1  synchronous, active-high reset
dispatch_valid  input  1  issue request
dispatch_ready  output  1  lane can accept this cycle
dispatch_1st_reg  input  XLEN  operand A
dispatch_2nd_reg  input  XLEN  operand B
dispatch_decoded_instruction  input  DECODED_INSTR_WIDTH  op code
dispatch_ROB_index  input  ROB_INDEX_WIDTH  destination ROB slot
dispatch_PC_i  input  XLEN  instruction PC
execute_ready  input  1  ROB accepts result
execute_valid  output  1  result valid at last stage
execute_ROB_index  output  ROB_INDEX_WIDTH  result ROB slot
execute_value  output  XLEN  result value
flush  input  1  discard all in-flight ops
inflight_count  output  CNT_WIDTH  number of valid entries held

Behaviour:
- Reset: synchronous on posedge clock, reset=1 (active-high), clock=clock. Clears every stage valid bit, execute_valid, execute_ROB_index, execute_value and inflight_count to 0. Data registers are reset to 0 for determinism.
- Operand select (combinational, ahead of stage 0):
  - op==LINK_OP -> ALU op 0 (ADD), A=INSTR_BYTES, B=dispatch_PC_i.
  - otherwise the inputs pass through unchanged.
- Stage chain: stage k holds {valid_k, rob_k, value_k}.
  - ready_k = ~valid_k | ready_{k+1}; ready_{PIPE_DEPTH} = execute_ready.
  - Stage k loads from stage k-1 (stage 0 loads from the ALU) when ready_k is high. Its valid becomes the upstream valid.
  - Data registers hold while ready_k is low.
- dispatch_ready = ready_0, a combinational path from execute_ready. A transfer happens when dispatch_valid & dispatch_ready.
- Latency: accept in cycle N gives execute_valid in cycle N+PIPE_DEPTH-1+1, i.e. output registered after PIPE_DEPTH edges, with no stall. Throughput is 1 op/cycle.
- Output = last stage. The result is retired on execute_valid & execute_ready.
- Stall: execute_ready=0 with the lane full -> dispatch_ready=0. Bubbles collapse, so the lane fills to PIPE_DEPTH entries before deasserting ready.
- Full + simultaneous retire + dispatch: both happen in the same cycle and the count is unchanged.
- Flush: on the next edge all valid bits are cleared. A dispatch presented in the flush cycle is dropped, even if dispatch_ready=1. The output presented in the flush cycle does not count as retired. inflight_count becomes 0.
- Reset and flush together: reset wins; the effect is identical.
- inflight_count: +1 on accept, -1 on retire, no change when both happen. Forced to 0 on flush or reset. Never exceeds PIPE_DEPTH (PIPE_DEPTH+1 with the skid option).

Optional Feature:
INTEGER_LANE_SKID_EN:
- Defined: a 1-entry skid register is placed before stage 0.
  - dispatch_ready = ~skid_full, a registered signal with no combinational path from execute_ready.
  - The skid captures an accepted op when ready_0=0 and drains first when ready_0 rises.
  - Flush clears the skid. Capacity is PIPE_DEPTH+1.
  - Zero-stall latency is unchanged (skid bypassed when empty).
- Undefined: dispatch_ready = ready_0 as described above.

Decomposition:
- Package int_lane_pkg:
  - ALU op code constants: ADD=6'd0, LINK=6'd1.
  - Default INSTR_BYTES.
  - Struct/typedef for the stage payload {rob_index, value}.
- One natural sub-module, lane_stage: a single elastic register with valid, payload, ready_in, ready_out and flush. It is instantiated PIPE_DEPTH times with a generate loop.
- The existing ALU is instantiated unchanged.

Test Plan:
- PIPE_DEPTH=2, ADD A=5, B=7, ROB=3, execute_ready=1 -> execute_valid after 2 edges, value 12, ROB 3, inflight_count back to 0.
- LINK_OP with PC=0x1000, operands 0xDEAD -> value 0x1004.
- Hold execute_ready=0 and dispatch ROB 1, 2, 3 back-to-back:
  - ROB 1 and 2 are accepted and dispatch_ready falls.
  - inflight_count=2; the output holds ROB 1 stable.
  - Release -> outputs 1, 2, 3 in order with no loss or duplication.
- Full lane, then execute_ready=1 and dispatch_valid=1 in the same cycle -> one retire, one accept, count stays 2.
- Flush with two in flight plus a dispatch in the flush cycle -> next cycle execute_valid=0, count=0, the dropped op never appears.
- Reset asserted mid-stream with 2 in flight -> all outputs 0 next cycle; the first op after release has normal latency.

Source files
------------

// File: rtl/pipelined_integer_lane_pkg.sv
// Shared constants and payload type for the integer execution lane.
// Consumed by pipelined_integer_lane, lane_stage and int_alu.
package int_lane_pkg;

  localparam logic [5:0] ALU_ADD  = 6'd0;
  localparam logic [5:0] ALU_LINK = 6'd1;
  localparam logic [5:0] ALU_SUB  = 6'd2;
  localparam logic [5:0] ALU_AND  = 6'd3;
  localparam logic [5:0] ALU_OR   = 6'd4;
  localparam logic [5:0] ALU_XOR  = 6'd5;
  localparam logic [5:0] ALU_SLL  = 6'd6;
  localparam logic [5:0] ALU_SRL  = 6'd7;
  localparam logic [5:0] ALU_SRA  = 6'd8;
  localparam logic [5:0] ALU_SLT  = 6'd9;
  localparam logic [5:0] ALU_SLTU = 6'd10;

  localparam int DEFAULT_INSTR_BYTES     = 4;
  localparam int DEFAULT_XLEN            = 64;
  localparam int DEFAULT_ROB_INDEX_WIDTH = 8;

  // Payload at default widths; the lane re-declares it with its own parameters.
  typedef struct packed {
    logic [DEFAULT_ROB_INDEX_WIDTH-1:0] rob_index;
    logic [DEFAULT_XLEN-1:0]            value;
  } lane_payload_t;

  function automatic int count_width(input int depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/pipelined_integer_lane_alu.sv
// Existing combinational integer ALU used by the execution lane.
module int_alu
  import int_lane_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [5:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_integer_lane_stage.sv
// One elastic valid/ready register; accepts whenever empty or draining downstream.
module lane_stage
  import int_lane_pkg::*;
#(
  parameter type payload_t = lane_payload_t
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     flush,
  input  logic     up_valid,
  input  payload_t up_payload,
  input  logic     ready_in,
  output logic     ready_out,
  output logic     valid,
  output payload_t payload
);

  logic     valid_reg;
  payload_t payload_reg;

  assign ready_out = ~valid_reg | ready_in;
  assign valid     = valid_reg;
  assign payload   = payload_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_reg   <= 1'b0;
      payload_reg <= '0;
    end else begin
      if (flush)
        valid_reg <= 1'b0;
      else if (ready_out)
        valid_reg <= up_valid;
      if (ready_out)
        payload_reg <= up_payload;
    end
  end

endmodule

// File: rtl/pipelined_integer_lane.sv
// Integer execution lane: ALU followed by PIPE_DEPTH elastic result stages.
// Optional INTEGER_LANE_SKID_EN adds a skid register so dispatch_ready is registered.
module pipelined_integer_lane
  import int_lane_pkg::*;
#(
  parameter int XLEN                = 64,
  parameter int ROB_INDEX_WIDTH     = 8,
  parameter int DECODED_INSTR_WIDTH = 6,
  parameter int PIPE_DEPTH          = 2,
  parameter logic [DECODED_INSTR_WIDTH-1:0] LINK_OP = 6'd1,
  parameter int INSTR_BYTES         = DEFAULT_INSTR_BYTES,
  parameter int CNT_WIDTH           = $clog2(PIPE_DEPTH + 2)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           dispatch_valid,
  output logic                           dispatch_ready,
  input  logic [XLEN-1:0]                dispatch_1st_reg,
  input  logic [XLEN-1:0]                dispatch_2nd_reg,
  input  logic [DECODED_INSTR_WIDTH-1:0] dispatch_decoded_instruction,
  input  logic [ROB_INDEX_WIDTH-1:0]     dispatch_ROB_index,
  input  logic [XLEN-1:0]                dispatch_PC_i,
  input  logic                           execute_ready,
  output logic                           execute_valid,
  output logic [ROB_INDEX_WIDTH-1:0]     execute_ROB_index,
  output logic [XLEN-1:0]                execute_value,
  input  logic                           flush,
  output logic [CNT_WIDTH-1:0]           inflight_count
);

  typedef struct packed {
    logic [ROB_INDEX_WIDTH-1:0] rob_index;
    logic [XLEN-1:0]            value;
  } payload_t;

  logic            is_link;
  logic [5:0]      alu_op;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  payload_t        alu_payload;

  // Link ops reuse the adder to form PC + INSTR_BYTES.
  assign is_link = (dispatch_decoded_instruction == LINK_OP);
  assign alu_op  = is_link ? ALU_ADD : dispatch_decoded_instruction[5:0];
  assign alu_a   = is_link ? XLEN'(INSTR_BYTES) : dispatch_1st_reg;
  assign alu_b   = is_link ? dispatch_PC_i : dispatch_2nd_reg;

  int_alu #(.XLEN(XLEN)) u_alu (
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result)
  );

  assign alu_payload.rob_index = dispatch_ROB_index;
  assign alu_payload.value     = alu_result;

  // Index 0 is the lane input; index k+1 is the output of stage k.
  logic [PIPE_DEPTH:0] stage_valid;
  logic [PIPE_DEPTH:0] stage_ready;
  payload_t            stage_payload [PIPE_DEPTH+1];

  assign stage_ready[PIPE_DEPTH] = execute_ready;

  generate
    for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_stage
      lane_stage #(.payload_t(payload_t)) u_stage (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .up_valid   (stage_valid[gi]),
        .up_payload (stage_payload[gi]),
        .ready_in   (stage_ready[gi+1]),
        .ready_out  (stage_ready[gi]),
        .valid      (stage_valid[gi+1]),
        .payload    (stage_payload[gi+1])
      );
    end
  endgenerate

`ifdef INTEGER_LANE_SKID_EN
  logic     skid_full_reg;
  payload_t skid_payload_reg;

  assign dispatch_ready   = ~skid_full_reg;
  assign stage_valid[0]   = skid_full_reg | dispatch_valid;
  assign stage_payload[0] = skid_full_reg ? skid_payload_reg : alu_payload;

  // The skid drains into stage 0 before any new op; accepts are blocked while full.
  always_ff @(posedge clock) begin
    if (reset) begin
      skid_full_reg    <= 1'b0;
      skid_payload_reg <= '0;
    end else if (flush) begin
      skid_full_reg <= 1'b0;
    end else if (skid_full_reg) begin
      if (stage_ready[0])
        skid_full_reg <= 1'b0;
    end else if (dispatch_valid && !stage_ready[0]) begin
      skid_full_reg    <= 1'b1;
      skid_payload_reg <= alu_payload;
    end
  end
`else
  assign dispatch_ready   = stage_ready[0];
  assign stage_valid[0]   = dispatch_valid;
  assign stage_payload[0] = alu_payload;
`endif

  assign execute_valid     = stage_valid[PIPE_DEPTH];
  assign execute_ROB_index = stage_payload[PIPE_DEPTH].rob_index;
  assign execute_value     = stage_payload[PIPE_DEPTH].value;

  logic                 accept;
  logic                 retire;
  logic [CNT_WIDTH-1:0] count_reg;
  logic [CNT_WIDTH-1:0] count_next;

  assign accept = dispatch_valid & dispatch_ready;
  assign retire = execute_valid & execute_ready;

  always_comb begin
    count_next = count_reg;
    if (accept && !retire)
      count_next = count_reg + CNT_WIDTH'(1);
    else if (retire && !accept)
      count_next = count_reg - CNT_WIDTH'(1);
  end

  always_ff @(posedge clock) begin
    if (reset || flush)
      count_reg <= '0;
    else
      count_reg <= count_next;
  end

  assign inflight_count = count_reg;

endmodule
